// File: rtl/dl_fec_pkg.sv
// Shared types and defaults for the downlink FEC controller.
// DL_FEC_CTRL_TIMEOUT_EN (in the top) selects the watchdog build.
package dl_fec_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
   localparam int unsigned WDOG_WIDTH         = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LAUNCH   = 3'd1,
      WAIT_ENC = 3'd2,
      OUTPUT   = 3'd3,
      ERR      = 3'd4
   } dl_fec_ctrl_state_t;

endpackage

// File: rtl/dl_fec_wdog.sv
// WAIT_ENC watchdog: load clears, enable counts, expire flags the
// last allowed cycle. Saturates so a stuck enable never wraps.
module dl_fec_wdog
   import dl_fec_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [WDOG_WIDTH-1:0] LAST =
      WDOG_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [WDOG_WIDTH-1:0] ONE = WDOG_WIDTH'(1);

   logic [WDOG_WIDTH-1:0] cnt_q;
   logic [WDOG_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/dl_fec_ctrl.sv
// Downlink FEC sequencer: launches CRC/encoder clusters, hands frame
// to framer. `DL_FEC_CTRL_TIMEOUT_EN adds the WAIT_ENC watchdog.
module dl_fec_ctrl
   import dl_fec_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_valid,
   output logic                 frame_ready,
   input  logic                 hdr_only,
   output logic                 crc0_start,
   output logic                 crc1_start,
   input  logic                 enc0_done,
   input  logic                 enc1_done,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 tx_hdr_only,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic                 err_timeout,
   input  logic                 err_clr
);

   dl_fec_ctrl_state_t state_q;

   logic                 hdr_only_q;
   logic                 d0_q;
   logic                 d1_q;
   logic                 crc0_start_q;
   logic                 crc1_start_q;
   logic                 tx_valid_q;
   logic                 busy_q;
   logic [CNT_WIDTH-1:0] frame_cnt_q;

   logic accept;
   logic both_done;
   logic timeout_now;

   assign frame_ready = (state_q == IDLE);
   assign accept      = frame_valid & frame_ready;

   // Header-only frames never start the 64-bit cluster, so its flag is implied.
   assign both_done = (d0_q | enc0_done | hdr_only_q)
                    & (d1_q | enc1_done);

`ifdef DL_FEC_CTRL_TIMEOUT_EN
   logic wd_expire;
   logic err_q;

   dl_fec_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .load_i   (state_q == LAUNCH),
      .en_i     (state_q == WAIT_ENC),
      .expire_o (wd_expire)
   );

   assign timeout_now = (state_q == WAIT_ENC) & wd_expire & ~both_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (timeout_now) begin
         err_q <= 1'b1;
      end else if (err_clr) begin
         err_q <= 1'b0;
      end
   end

   assign err_timeout = err_q;
`else
   localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign timeout_now    = 1'b0;
   assign err_timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hdr_only_q   <= 1'b0;
         d0_q         <= 1'b0;
         d1_q         <= 1'b0;
         crc0_start_q <= 1'b0;
         crc1_start_q <= 1'b0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         crc0_start_q <= 1'b0;
         crc1_start_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q      <= LAUNCH;
                  hdr_only_q   <= hdr_only;
                  d0_q         <= 1'b0;
                  d1_q         <= 1'b0;
                  crc0_start_q <= ~hdr_only;
                  crc1_start_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            LAUNCH: begin
               state_q <= WAIT_ENC;
            end
            WAIT_ENC: begin
               d0_q <= d0_q | enc0_done;
               d1_q <= d1_q | enc1_done;
               if (both_done) begin
                  state_q    <= OUTPUT;
                  tx_valid_q <= 1'b1;
               end else if (timeout_now) begin
                  state_q <= ERR;
               end
            end
            OUTPUT: begin
               if (tx_ready) begin
                  state_q     <= IDLE;
                  tx_valid_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
               end
            end
`ifdef DL_FEC_CTRL_TIMEOUT_EN
            ERR: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
`endif
            default: begin
               state_q    <= IDLE;
               tx_valid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign crc0_start  = crc0_start_q;
   assign crc1_start  = crc1_start_q;
   assign tx_valid    = tx_valid_q;
   assign tx_hdr_only = hdr_only_q;
   assign busy        = busy_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dl_fec_ctrl.sv
// Directed bench for dl_fec_ctrl; the timeout scenario is exercised
// when DL_FEC_CTRL_TIMEOUT_EN is defined.
module tb_dl_fec_ctrl;

`ifdef DL_FEC_CTRL_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic        clk;
   logic        rst;
   logic        frame_valid;
   logic        frame_ready;
   logic        hdr_only;
   logic        crc0_start;
   logic        crc1_start;
   logic        enc0_done;
   logic        enc1_done;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_hdr_only;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        err_timeout;
   logic        err_clr;

   int checks = 0;
   int errors = 0;
   int n_crc0 = 0;
   int n_crc1 = 0;
   int n_txv  = 0;
   int txv_snap;

   dl_fec_ctrl #(
      .TIMEOUT_CYCLES(TO),
      .CNT_WIDTH(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .hdr_only    (hdr_only),
      .crc0_start  (crc0_start),
      .crc1_start  (crc1_start),
      .enc0_done   (enc0_done),
      .enc1_done   (enc1_done),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_hdr_only (tx_hdr_only),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .err_timeout (err_timeout),
      .err_clr     (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (crc0_start) n_crc0++;
      if (crc1_start) n_crc1++;
      if (tx_valid) n_txv++;
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      frame_valid = 1'b0;
      hdr_only = 1'b0;
      enc0_done = 1'b0;
      enc1_done = 1'b0;
      tx_ready = 1'b0;
      err_clr = 1'b0;
      tick();
      tick();
      chk("rst_crc0", 32'(crc0_start), 0);
      chk("rst_crc1", 32'(crc1_start), 0);
      chk("rst_txv", 32'(tx_valid), 0);
      chk("rst_txhdr", 32'(tx_hdr_only), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt", 32'(frame_cnt), 0);
      chk("rst_err", 32'(err_timeout), 0);
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(frame_ready), 1);

      // full frame, enc0 at L+3, enc1 at L+5
      frame_valid = 1'b1;
      hdr_only = 1'b0;
      tick();
      frame_valid = 1'b0;
      chk("s1_crc0", 32'(crc0_start), 1);
      chk("s1_crc1", 32'(crc1_start), 1);
      chk("s1_ready", 32'(frame_ready), 0);
      chk("s1_busy", 32'(busy), 1);
      tick();
      chk("s1_crc0_off", 32'(crc0_start), 0);
      chk("s1_crc1_off", 32'(crc1_start), 0);
      tick();
      tick();
      enc0_done = 1'b1;
      tick();
      enc0_done = 1'b0;
      chk("s1_txv_early", 32'(tx_valid), 0);
      tick();
      enc1_done = 1'b1;
      tx_ready = 1'b1;
      tick();
      enc1_done = 1'b0;
      chk("s1_txv", 32'(tx_valid), 1);
      chk("s1_txhdr", 32'(tx_hdr_only), 0);
      chk("s1_cnt_pre", 32'(frame_cnt), 0);
      tick();
      tx_ready = 1'b0;
      chk("s1_txv_off", 32'(tx_valid), 0);
      chk("s1_cnt", 32'(frame_cnt), 1);
      chk("s1_busy_off", 32'(busy), 0);
      chk("s1_n_crc0", 32'(n_crc0), 1);
      chk("s1_n_crc1", 32'(n_crc1), 1);
      chk("s1_n_txv", 32'(n_txv), 1);

      // header-only frame
      frame_valid = 1'b1;
      hdr_only = 1'b1;
      tick();
      frame_valid = 1'b0;
      hdr_only = 1'b0;
      chk("s2_crc0", 32'(crc0_start), 0);
      chk("s2_crc1", 32'(crc1_start), 1);
      tick();
      enc1_done = 1'b1;
      tick();
      enc1_done = 1'b0;
      chk("s2_txv", 32'(tx_valid), 1);
      chk("s2_txhdr", 32'(tx_hdr_only), 1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("s2_cnt", 32'(frame_cnt), 2);
      chk("s2_n_crc0", 32'(n_crc0), 1);
      chk("s2_n_crc1", 32'(n_crc1), 2);

      // stray dones in IDLE and LAUNCH, then same-cycle dones
      enc0_done = 1'b1;
      enc1_done = 1'b1;
      tick();
      enc0_done = 1'b0;
      enc1_done = 1'b0;
      frame_valid = 1'b1;
      hdr_only = 1'b0;
      tick();
      enc0_done = 1'b1;
      enc1_done = 1'b1;
      tick();
      enc0_done = 1'b0;
      enc1_done = 1'b0;
      chk("s3_wait_busy", 32'(busy), 1);
      tick();
      chk("s3_stray_ignored", 32'(tx_valid), 0);
      enc0_done = 1'b1;
      enc1_done = 1'b1;
      tick();
      enc0_done = 1'b0;
      enc1_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("s3_txv_hold", 32'(tx_valid), 1);
         chk("s3_no_accept", 32'(frame_ready), 0);
         tick();
      end
      tx_ready = 1'b1;
      tick();
      chk("s3_cnt", 32'(frame_cnt), 3);
      chk("s3_ready", 32'(frame_ready), 1);
      tick();
      frame_valid = 1'b0;
      chk("s3b_crc1", 32'(crc1_start), 1);
      tick();
      enc0_done = 1'b1;
      enc1_done = 1'b1;
      tick();
      enc0_done = 1'b0;
      enc1_done = 1'b0;
      chk("s3b_txv", 32'(tx_valid), 1);
      tick();
      tx_ready = 1'b0;
      chk("s3b_cnt", 32'(frame_cnt), 4);

      // counter wrap
      force dut.frame_cnt_q = 16'hFFFF;
      tick();
      release dut.frame_cnt_q;
      tick();
      chk("s4_cnt_pre", 32'(frame_cnt), 32'h0000FFFF);
      frame_valid = 1'b1;
      hdr_only = 1'b1;
      tick();
      frame_valid = 1'b0;
      hdr_only = 1'b0;
      tick();
      enc1_done = 1'b1;
      tick();
      enc1_done = 1'b0;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("s4_cnt_wrap", 32'(frame_cnt), 0);

`ifdef DL_FEC_CTRL_TIMEOUT_EN
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      repeat (8) tick();
      chk("s5_err_pre", 32'(err_timeout), 0);
      chk("s5_busy_wait", 32'(busy), 1);
      tick();
      chk("s5_err_set", 32'(err_timeout), 1);
      chk("s5_txv", 32'(tx_valid), 0);
      tick();
      chk("s5_idle", 32'(busy), 0);
      chk("s5_err_sticky", 32'(err_timeout), 1);
      chk("s5_cnt", 32'(frame_cnt), 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("s5_err_clr", 32'(err_timeout), 0);
`else
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("s5_err_tied", 32'(err_timeout), 0);
`endif

      // reset mid-frame, then late dones
      txv_snap = n_txv;
      frame_valid = 1'b1;
      hdr_only = 1'b0;
      tick();
      frame_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      enc0_done = 1'b1;
      enc1_done = 1'b1;
      tick();
      enc0_done = 1'b0;
      enc1_done = 1'b0;
      chk("s6_busy", 32'(busy), 0);
      chk("s6_txv", 32'(tx_valid), 0);
      chk("s6_cnt", 32'(frame_cnt), 0);
      chk("s6_ready", 32'(frame_ready), 1);
      tick();
      tick();
      chk("s6_no_txv", 32'(n_txv - txv_snap), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
